// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: fetch FSM state encoding and reset defaults shared by the fetch unit
package instruction_fetch_pkg;
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    MEMWAIT = 2'd1,
    LOAD    = 2'd2,
    EXEC    = 2'd3
  } state_e;
  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam logic [15:0] NOP_WORD_DEFAULT = 16'h0000;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: memory, datapath and decoder signals of the fetch unit
interface instruction_fetch_if;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_rdata;
  logic        stall;
  logic        exec_done;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic        executing;
  modport master (
    output mem_addr, mem_rd_en, instruction, instr_valid, pc, pc_plus1, executing,
    input  mem_rdata, stall, exec_done, branch_taken, branch_target
  );
  modport slave (
    input  mem_addr, mem_rd_en, instruction, instr_valid, pc, pc_plus1, executing,
    output mem_rdata, stall, exec_done, branch_taken, branch_target
  );
endinterface

// File: rtl/instruction_fetch_program_counter.sv
// program_counter: pc register with branch load and wrapping increment
module program_counter
  import instruction_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic        inc_en,
  input  logic [15:0] target,
  output logic [15:0] pc,
  output logic [15:0] pc_plus1
);
  logic [15:0] pc_d, pc_q;
  // branch load has priority over increment; otherwise hold
  always_comb pc_d = load_en ? target : inc_en ? pc_plus1 : pc_q;
  // pc register, synchronous active-low reset
  always_ff @(posedge clk)
    if (!reset) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  assign pc       = pc_q;
  assign pc_plus1 = pc_q + 16'd1;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: four-state fetch FSM driving the program counter and instruction register
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [15:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  instruction_fetch_if.master  bus
);
  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        load_en, inc_en;
  logic [15:0] pc, pc_plus1;
  program_counter #(.RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .reset    (reset),
    .load_en  (load_en),
    .inc_en   (inc_en),
    .target   (bus.branch_target),
    .pc       (pc),
    .pc_plus1 (pc_plus1)
  );
  // state register
  always_ff @(posedge clk)
    if (!reset) state_q <= FETCH;
    else state_q <= state_d;
  // instruction register; reset drops any read still in flight
  always_ff @(posedge clk)
    if (!reset) ir_q <= NOP_WORD;
    else ir_q <= ir_d;
  // next state: stall only matters in FETCH, exec_done only in EXEC
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = bus.stall ? FETCH : MEMWAIT;
      MEMWAIT: state_d = LOAD;
      LOAD:    state_d = EXEC;
      EXEC:    state_d = bus.exec_done ? FETCH : EXEC;
    endcase
  end
  // outputs; read data is only valid in MEMWAIT, so IR captures it there and shows it while instr_valid pulses in LOAD
  always_comb begin
    ir_d            = state_q == MEMWAIT ? bus.mem_rdata : ir_q;
    load_en         = state_q == EXEC && bus.exec_done && bus.branch_taken;
    inc_en          = state_q == EXEC && bus.exec_done && !bus.branch_taken;
    bus.mem_rd_en   = reset && state_q == FETCH && !bus.stall;
    bus.instr_valid = state_q == LOAD;
    bus.executing   = state_q == EXEC;
  end
  assign bus.mem_addr    = pc;
  assign bus.pc          = pc;
  assign bus.pc_plus1    = pc_plus1;
  assign bus.instruction = ir_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed stimulus with queued expectations checked by a separate monitor
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rd_cyc = 0;
  logic        pend = 1'b0;
  logic [15:0] raddr = 16'h0000;
  logic [15:0] rd_q[$];
  logic [31:0] iv_q[$];

  instruction_fetch_if bus();

  instruction_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return a == 16'h0000 ? 16'h5103 : a ^ 16'hA5A5;
  endfunction

  // memory: data valid only in the cycle after the read strobe
  always @(posedge clk) begin
    pend  <= reset && bus.mem_rd_en;
    raddr <= bus.mem_addr;
  end
  assign bus.mem_rdata = pend ? mem_f(raddr) : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: pops expectations whenever the DUT reads or presents an instruction
  initial forever begin
    logic [15:0] ea;
    logic [31:0] ev;
    @(negedge clk);
    if (bus.mem_rd_en) begin
      if (rd_q.size() == 0) chk("unexpected_read", {16'h0, bus.mem_addr}, 32'hFFFFFFFF);
      else begin
        ea = rd_q.pop_front();
        chk("read_addr", {16'h0, bus.mem_addr}, {16'h0, ea});
      end
      rd_cyc = cyc;
    end
    if (bus.instr_valid) begin
      if (iv_q.size() == 0) chk("unexpected_instr", {bus.pc, bus.instruction}, 32'hFFFFFFFF);
      else begin
        ev = iv_q.pop_front();
        chk("instr_pc_ir", {bus.pc, bus.instruction}, ev);
        chk("instr_latency", cyc - rd_cyc, 2);
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_executing"}, {31'h0, bus.executing}, 0);
    chk({tag, "_pc"}, {16'h0, bus.pc}, 32'h0000);
    chk({tag, "_pc_plus1"}, {16'h0, bus.pc_plus1}, 32'h0001);
    chk({tag, "_ir"}, {16'h0, bus.instruction}, 32'h0000);
    chk({tag, "_instr_valid"}, {31'h0, bus.instr_valid}, 0);
    chk({tag, "_rd_en"}, {31'h0, bus.mem_rd_en}, 0);
  endtask

  // one instruction starting in an unstalled FETCH cycle at address a
  task automatic run_instr(input logic [15:0] a, input bit br, input logic [15:0] tgt,
                           input int hold, input bit stall_next);
    logic [15:0] nxt, nxt1;
    int t0;
    nxt  = br ? tgt : a + 16'd1;
    nxt1 = nxt + 16'd1;
    bus.stall = 1'b0;
    rd_q.push_back(a);
    iv_q.push_back({a, mem_f(a)});
    #1;
    chk("fetch_rd_en", {31'h0, bus.mem_rd_en}, 1);
    t0 = cyc;
    tick();
    bus.stall = 1'b1;
    bus.exec_done = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_target = 16'hBEEF;
    tick();
    tick();
    chk("exec_flag", {31'h0, bus.executing}, 1);
    chk("exec_pc", {16'h0, bus.pc}, {16'h0, a});
    chk("exec_ir", {16'h0, bus.instruction}, {16'h0, mem_f(a)});
    repeat (hold) begin
      bus.exec_done = 1'b0;
      tick();
      chk("hold_exec", {31'h0, bus.executing}, 1);
      chk("hold_pc", {16'h0, bus.pc}, {16'h0, a});
    end
    bus.exec_done = 1'b1;
    bus.branch_taken = br;
    bus.branch_target = tgt;
    bus.stall = stall_next;
    tick();
    bus.exec_done = 1'b0;
    bus.branch_taken = 1'b0;
    chk("next_exec_flag", {31'h0, bus.executing}, 0);
    chk("next_pc", {16'h0, bus.pc}, {16'h0, nxt});
    chk("next_addr", {16'h0, bus.mem_addr}, {16'h0, nxt});
    chk("next_pc_plus1", {16'h0, bus.pc_plus1}, {16'h0, nxt1});
    chk("period", cyc - t0, 4 + hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bus.stall = 1'b0;
    bus.exec_done = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 16'h0000;
    tick();
    tick();
    reset_checks("reset");
    reset = 1'b1;
    run_instr(16'h0000, 1'b0, 16'h0000, 0, 1'b0);
    run_instr(16'h0001, 1'b1, 16'h0040, 1, 1'b0);
    run_instr(16'h0040, 1'b1, 16'h0040, 0, 1'b0);
    run_instr(16'h0040, 1'b1, 16'hFFFF, 0, 1'b0);
    run_instr(16'hFFFF, 1'b0, 16'h0000, 0, 1'b1);
    repeat (3) begin
      bus.exec_done = 1'b1;
      bus.branch_taken = 1'b1;
      bus.branch_target = 16'h1234;
      chk("stall_rd_en", {31'h0, bus.mem_rd_en}, 0);
      chk("stall_pc", {16'h0, bus.pc}, 32'h0000);
      tick();
    end
    bus.exec_done = 1'b0;
    bus.branch_taken = 1'b0;
    chk("stall_end_pc", {16'h0, bus.pc}, 32'h0000);
    run_instr(16'h0000, 1'b1, 16'h0123, 0, 1'b0);
    rd_q.push_back(16'h0123);
    tick();
    reset = 1'b0;
    tick();
    reset_checks("memwait_reset");
    reset = 1'b1;
    run_instr(16'h0000, 1'b1, 16'h0040, 0, 1'b0);
    rd_q.push_back(16'h0040);
    iv_q.push_back({16'h0040, mem_f(16'h0040)});
    tick();
    tick();
    tick();
    chk("pre_reset_exec", {31'h0, bus.executing}, 1);
    chk("pre_reset_ir", {16'h0, bus.instruction}, {16'h0, mem_f(16'h0040)});
    reset = 1'b0;
    tick();
    reset_checks("exec_reset");
    tick();
    chk("held_reset_rd_en", {31'h0, bus.mem_rd_en}, 0);
    chk("rd_queue_drained", rd_q.size(), 0);
    chk("iv_queue_drained", iv_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 16'h0000, IR value loaded on reset (decodes as WAIT/NOP).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 mem_addr  output  16  instruction memory address.
REQ-006 mem_rd_en  output  1  instruction memory read strobe.
REQ-007 mem_rdata  input  16  instruction memory read data; valid exactly one cycle after the mem_rd_en cycle.
REQ-008 stall  input  1  hold fetch; no new read issued while high.
REQ-009 exec_done  input  1  datapath finished the current instruction.
REQ-010 branch_taken  input  1  qualifies exec_done; load branch_target instead of PC+1.
REQ-011 branch_target  input  16  next PC when branch_taken.
REQ-012 instruction  output  16  instruction register (IR), feeds the decoder.
REQ-013 instr_valid  output  1  one-cycle pulse on the cycle IR takes a new value.
REQ-014 pc  output  16  address of the instruction in IR.
REQ-015 pc_plus1  output  16  pc+1 modulo 2^16, for link/return use.
REQ-016 executing  output  1  high while the FSM is in EXEC.

Function
REQ-017 FSM states FETCH, MEMWAIT, LOAD, EXEC; reset state FETCH.
REQ-018 FETCH: mem_addr=pc, mem_rd_en=1 when stall=0; stall=1 -> mem_rd_en=0, remain in FETCH; stall=0 -> MEMWAIT.
REQ-019 MEMWAIT: mem_rd_en=0; unconditionally -> LOAD next cycle.
REQ-020 LOAD: IR <= mem_rdata, instr_valid=1 for this cycle only; -> EXEC.
REQ-021 EXEC: executing=1; IR and pc held; exec_done=0 -> remain in EXEC.
REQ-022 EXEC with exec_done=1 -> FETCH; pc <= branch_target if branch_taken=1, else pc+1.
REQ-023 PC increment wraps 16'hFFFF -> 16'h0000 with no flag.
REQ-024 exec_done and branch_taken are ignored in every state other than EXEC.
REQ-025 stall is sampled only in FETCH; a stall asserted in MEMWAIT/LOAD/EXEC does not abort the in-flight fetch.
REQ-026 Latency: FETCH cycle with stall=0 to instr_valid pulse = 2 cycles; minimum instruction period = 4 cycles.
REQ-027 mem_addr equals pc in every state (combinational from pc register).
REQ-028 pc_plus1 combinational from pc; executing combinational from state.
REQ-029 branch_target equal to current pc is legal: refetch same address.

Reset
REQ-030 On reset=0 at a clock edge: state=FETCH, pc=RESET_PC, IR=NOP_WORD, instr_valid=0, regardless of current state (including mid-EXEC or MEMWAIT).
REQ-031 While reset=0: mem_rd_en=0; first read issues on the first edge-sampled cycle with reset=1 and stall=0.
REQ-032 Memory data returning after a mid-fetch reset is discarded.

Structure
REQ-033 Shared package holds the 2-bit state encoding (FETCH=0, MEMWAIT=1, LOAD=2, EXEC=3), RESET_PC and NOP_WORD defaults.
REQ-034 One sub-module, program_counter: holds pc, inputs load_en/inc_en/target, outputs pc and pc_plus1; FSM in instruction_fetch drives it.

Verification
REQ-035 Reset release, stall=0, mem[0]=16'h5103 -> mem_rd_en at addr 0, instr_valid pulse 2 cycles later, instruction=16'h5103, pc=0.
REQ-036 exec_done=1 branch_taken=0 in first EXEC cycle -> next fetch at addr 1; instruction period exactly 4 cycles.
REQ-037 exec_done=1 branch_taken=1 branch_target=16'h0040 -> next mem_addr=16'h0040, pc_plus1=16'h0041.
REQ-038 pc=16'hFFFF, exec_done without branch -> next fetch at 16'h0000.
REQ-039 stall=1 for 3 cycles in FETCH -> mem_rd_en=0 those cycles, read issued on first stall=0 cycle; exec_done pulsed in FETCH has no effect on pc.
REQ-040 reset=0 asserted in MEMWAIT and in EXEC -> next cycle state=FETCH, pc=RESET_PC, instruction=16'h0000, instr_valid=0.
